// File: rtl/instruction_fetch_unit.sv
// IF stage: PC ownership, next-PC selection and a wait-state tolerant imem handshake.
// Re-presents a held word while stalled, since IF/ID has no write enable.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] jrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructionIn,
  output logic [31:0] PCplus4,
  output logic        IF_Flush,
  output logic        addr_misalign
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4      = pc_q + 32'd4;
  assign imem_addr     = pc_q;
  assign addr_misalign = misalign_q;

  // BOOT ignores redirects; PCSrc only matters when the PC may advance
  assign redirect = PCWrite
                  && (PCSrc != 2'b00)
                  && (state_q != S_BOOT);

  always_comb begin
    target = pc_plus4;
    unique case (1'b1)
      (PCSrc == 2'b01): target = branchTarget;
      (PCSrc == 2'b10): target = jumpTarget;
      (PCSrc == 2'b11): target = jrTarget;
      default:          target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      hold_buf_q <= 32'h0;
      hold_pc4_q <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
      hold_pc4_q <= hold_pc4_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_buf_d = hold_buf_q;
    hold_pc4_d = hold_pc4_q;
    misalign_d = misalign_q;
    if (redirect) begin
      state_d = S_REQ;
      pc_d    = {target[31:2], 2'b00};
      if (target[1:0] != 2'b00)
        misalign_d = 1'b1;
    end else begin
      unique case (1'b1)
        (state_q == S_BOOT): state_d = S_REQ;
        (state_q == S_REQ): begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (!PCWrite) begin
              // capture the word so it can be re-presented while stalled
              hold_buf_d = imem_rdata;
              hold_pc4_d = pc_plus4;
              state_d    = S_HOLD;
            end
          end
        end
        (state_q == S_HOLD): begin
          if (PCWrite)
            state_d = S_REQ;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    imem_req      = 1'b0;
    IF_Flush      = 1'b1;
    instructionIn = 32'h0;
    PCplus4       = pc_plus4;
    unique case (1'b1)
      (state_q == S_REQ): begin
        imem_req = 1'b1;
        if (imem_ready && !redirect) begin
          IF_Flush      = 1'b0;
          instructionIn = imem_rdata;
        end
      end
      (state_q == S_HOLD): begin
        IF_Flush      = redirect;
        instructionIn = hold_buf_q;
        PCplus4       = hold_pc4_q;
      end
      default: begin
        IF_Flush = 1'b1;
      end
    endcase
  end

endmodule
